// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Grant and state encodings used by the top and the picker.
package mem_arb_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_e;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_IF,
      GNT_DRD,
      GNT_DWR
   } gnt_e;

   // Bits needed to hold a counter that reaches max_val.
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant selection: writes over reads over fetch,
// unless fetch has waited too long behind data traffic.
module mem_arb_picker
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic drd_req,
   input  logic dwr_req,
   input  logic starve,
   output gnt_e gnt
);

   always_comb begin
      gnt = GNT_NONE;
      if (starve && if_req) begin
         gnt = GNT_IF;
      end else if (dwr_req) begin
         gnt = GNT_DWR;
      end else if (drd_req) begin
         gnt = GNT_DRD;
      end else if (if_req) begin
         gnt = GNT_IF;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch, data-read and data-write ports onto one memory bus,
// with fetch starvation protection and a bus timeout with sticky error.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_ack_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                drd_req_i,
   input  logic [ADDR_W-1:0]   drd_addr_i,
   output logic                drd_ack_o,
   output logic [DATA_W-1:0]   drd_rdata_o,
   input  logic                dwr_req_i,
   input  logic [ADDR_W-1:0]   dwr_addr_i,
   input  logic [DATA_W-1:0]   dwr_wdata_i,
   input  logic [DATA_W/8-1:0] dwr_wmask_i,
   output logic                dwr_ack_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_wmask_o,
   input  logic                mem_ack_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                stall_o,
   output logic                err_o,
   output logic [ADDR_W-1:0]   err_addr_o
);

   localparam int MASK_W = DATA_W / 8;
   localparam int TMO_W  = cnt_width(TIMEOUT);
   localparam int STV_W  = cnt_width(STARVE_MAX);

   state_e           state;
   state_e           state_nx;
   gnt_e             pick;
   gnt_e             gnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [STV_W-1:0] starve_cnt;
   logic             starve;
   logic             expired;
   logic             issue;
   logic             done;
   logic             abort;

   assign starve  = (starve_cnt == STV_W'(STARVE_MAX));
   assign expired = (tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign issue   = (state == ST_IDLE) && (pick != GNT_NONE);
   assign done    = (state == ST_WAIT) && (mem_ack_i || expired);
   assign abort   = done && !mem_ack_i;

   assign stall_o = (if_req_i  && !if_ack_o)
                 || (drd_req_i && !drd_ack_o)
                 || (dwr_req_i && !dwr_ack_o);

   mem_arb_picker u_picker (
      .if_req  (if_req_i),
      .drd_req (drd_req_i),
      .dwr_req (dwr_req_i),
      .starve  (starve),
      .gnt     (pick)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: if (issue) state_nx = ST_WAIT;
         ST_WAIT: if (done)  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Request fields are captured once at grant and held through WAIT.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         gnt         <= GNT_NONE;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_wmask_o <= '0;
      end else if (issue) begin
         gnt      <= pick;
         mem_we_o <= (pick == GNT_DWR);
         unique case (pick)
            GNT_DWR: begin
               mem_addr_o  <= dwr_addr_i;
               mem_wdata_o <= dwr_wdata_i;
               mem_wmask_o <= dwr_wmask_i;
            end
            GNT_DRD: begin
               mem_addr_o  <= drd_addr_i;
               mem_wdata_o <= '0;
               mem_wmask_o <= MASK_W'(0);
            end
            default: begin
               mem_addr_o  <= if_addr_i;
               mem_wdata_o <= '0;
               mem_wmask_o <= MASK_W'(0);
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mem_req_o <= 1'b0;
      end else if (issue) begin
         mem_req_o <= 1'b1;
      end else if (done) begin
         mem_req_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tmo_cnt <= '0;
      end else if ((state == ST_WAIT) && !done) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         if_ack_o  <= 1'b0;
         drd_ack_o <= 1'b0;
         dwr_ack_o <= 1'b0;
      end else begin
         if_ack_o  <= done && (gnt == GNT_IF);
         drd_ack_o <= done && (gnt == GNT_DRD);
         dwr_ack_o <= done && (gnt == GNT_DWR);
      end
   end

   // An aborted read returns zero rather than whatever is on the bus.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         if_rdata_o  <= '0;
         drd_rdata_o <= '0;
      end else if (done) begin
         if (gnt == GNT_IF) begin
            if_rdata_o <= abort ? '0 : mem_rdata_i;
         end
         if (gnt == GNT_DRD) begin
            drd_rdata_o <= abort ? '0 : mem_rdata_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         err_o      <= 1'b0;
         err_addr_o <= '0;
      end else if (abort) begin
         err_o <= 1'b1;
         if (!err_o) begin
            err_addr_o <= mem_addr_o;
         end
      end
   end

   // Counts data grants won while fetch was waiting.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         starve_cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (!if_req_i || (pick == GNT_IF)) begin
            starve_cnt <= '0;
         end else if ((pick != GNT_NONE) && !starve) begin
            starve_cnt <= starve_cnt + STV_W'(1);
         end
      end
   end

endmodule
